// File: rtl/regfile_sb_if.sv
// Issue/writeback side bundle for the scoreboarded register file.
// The master drives indices, writes and reserves; the slave returns data and busy state.
interface regfile_sb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] r1;
   logic [ADDR_WIDTH-1:0] r2;
   logic [DATA_WIDTH-1:0] r1_value;
   logic [DATA_WIDTH-1:0] r2_value;
   logic [ADDR_WIDTH-1:0] r3;
   logic [DATA_WIDTH-1:0] r3_value;
   logic                  writeEnable;
   logic                  raWrite;
   logic [DATA_WIDTH-1:0] ra_value;
   logic [DATA_WIDTH-1:0] ra_read_value;
   logic                  reserveEnable;
   logic [ADDR_WIDTH-1:0] reserve_reg;
   logic                  r1_busy;
   logic                  r2_busy;
   logic [ADDR_WIDTH:0]   busyCount;

   modport master (
      output r1, r2, r3, r3_value, writeEnable,
      output raWrite, ra_value, reserveEnable, reserve_reg,
      input  r1_value, r2_value, ra_read_value,
      input  r1_busy, r2_busy, busyCount
   );

   modport slave (
      input  r1, r2, r3, r3_value, writeEnable,
      input  raWrite, ra_value, reserveEnable, reserve_reg,
      output r1_value, r2_value, ra_read_value,
      output r1_busy, r2_busy, busyCount
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with link port, zero register, optional write bypass
// and a per-register busy scoreboard for issue-stage stalls.
module regfile_sb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int RA_INDEX   = 31,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input logic        clk,
   input logic        rst_n,
   regfile_sb_if.slave bus
);
   localparam int NUM_REGS = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] RA = ADDR_WIDTH'(RA_INDEX);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

   logic [ADDR_WIDTH-1:0] r3, rr;
   logic [DATA_WIDTH-1:0] r3_value, ra_value;
   logic                  gp_we, ra_we, res_ok;

   assign r3       = bus.r3;
   assign rr       = bus.reserve_reg;
   assign r3_value = bus.r3_value;
   assign ra_value = bus.ra_value;

   function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
      return (ZERO_REG != 0) && (idx == '0);
   endfunction

   assign gp_we  = bus.writeEnable && !is_zero(r3);
   assign ra_we  = bus.raWrite && !is_zero(RA);
   assign res_ok = bus.reserveEnable && !is_zero(rr);

   function automatic logic wr_hit(input logic [ADDR_WIDTH-1:0] idx);
      return (ra_we && idx == RA) || (gp_we && idx == r3);
   endfunction

   // Link port wins over the general port on the same index.
   function automatic logic [DATA_WIDTH-1:0] wr_data(
      input logic [ADDR_WIDTH-1:0] idx);
      return (ra_we && idx == RA) ? ra_value : r3_value;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] rd(
      input logic [ADDR_WIDTH-1:0] idx);
      if (!rst_n || is_zero(idx))
         return '0;
      else if (BYPASS != 0 && wr_hit(idx))
         return wr_data(idx);
      else
         return regs_q[idx];
   endfunction

   function automatic logic bsy(input logic [ADDR_WIDTH-1:0] idx);
      if (!rst_n || is_zero(idx))
         return 1'b0;
      else if (BYPASS != 0 && wr_hit(idx) && !(res_ok && rr == idx))
         return 1'b0;
      else
         return busy_q[idx];
   endfunction

   assign bus.r1_value      = rd(bus.r1);
   assign bus.r2_value      = rd(bus.r2);
   assign bus.ra_read_value = rd(RA);
   assign bus.r1_busy       = bsy(bus.r1);
   assign bus.r2_busy       = bsy(bus.r2);
   assign bus.busyCount     = cnt_q;

   // A reserve in the same cycle as a write keeps the bit set.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = wr_hit(ADDR_WIDTH'(i)) ?
                     wr_data(ADDR_WIDTH'(i)) : regs_q[i];
         if (res_ok && rr == ADDR_WIDTH'(i))
            busy_d[i] = 1'b1;
         else if (wr_hit(ADDR_WIDTH'(i)))
            busy_d[i] = 1'b0;
         else
            busy_d[i] = busy_q[i];
         cnt_d = cnt_d + (ADDR_WIDTH+1)'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= regs_d[i];
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: stimulus queues expectations, a negedge monitor
// pops and compares them against the register file outputs.
module tb_regfile_sb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   regfile_sb dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   typedef enum int {R1V, R2V, RAV, R1B, R2B, CNT} sel_t;
   typedef struct {
      string       name;
      sel_t        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   function automatic void expect_v(string n, sel_t s, logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sel  = s;
      e.exp  = v;
      q.push_back(e);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            unique case (e.sel)
               R1V: act = bus.r1_value;
               R2V: act = bus.r2_value;
               RAV: act = bus.ra_read_value;
               R1B: act = {31'd0, bus.r1_busy};
               R2B: act = {31'd0, bus.r2_busy};
               CNT: act = {26'd0, bus.busyCount};
            endcase
            n_chk++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
         end
      end
   end

   task automatic idle();
      bus.writeEnable   = 1'b0;
      bus.raWrite       = 1'b0;
      bus.reserveEnable = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.writeEnable = 1'b1;
      bus.r3          = a;
      bus.r3_value    = d;
   endtask

   task automatic rsv(input logic [4:0] a);
      bus.reserveEnable = 1'b1;
      bus.reserve_reg   = a;
   endtask

   initial begin
      idle();
      bus.r1 = 5'd4;
      bus.r2 = 5'd2;
      bus.r3 = '0;
      bus.r3_value = '0;
      bus.ra_value = '0;
      bus.reserve_reg = '0;
      expect_v("rst_r1", R1V, 32'd0);
      expect_v("rst_r2", R2V, 32'd0);
      expect_v("rst_ra", RAV, 32'd0);
      expect_v("rst_cnt", CNT, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      step(); wr(7, 32'd88); bus.r1 = 7;
      expect_v("bypass_r7", R1V, 32'd88);
      step(); bus.r1 = 7;
      expect_v("read_r7", R1V, 32'd88);

      step(); rsv(31);
      step();
      bus.raWrite = 1'b1; bus.ra_value = 32'd77;
      wr(31, 32'd55); bus.r2 = 31; bus.r1 = 31;
      expect_v("link_wins_byp", R2V, 32'd77);
      expect_v("ra_byp", RAV, 32'd77);
      expect_v("r31_busy_byp", R1B, 32'd0);
      expect_v("cnt_r31_busy", CNT, 32'd1);
      step(); bus.r2 = 31; bus.r1 = 31;
      expect_v("link_wins", R2V, 32'd77);
      expect_v("ra_read", RAV, 32'd77);
      expect_v("r31_cleared", R1B, 32'd0);
      expect_v("cnt_after_link", CNT, 32'd0);

      step(); wr(0, 32'd123); bus.r1 = 0;
      expect_v("zero_byp", R1V, 32'd0);
      step(); rsv(0); bus.r1 = 0;
      expect_v("zero_read", R1V, 32'd0);
      expect_v("zero_busy", R1B, 32'd0);
      step(); bus.r1 = 0;
      expect_v("zero_cnt", CNT, 32'd0);
      expect_v("zero_busy2", R1B, 32'd0);

      step(); rsv(5);
      step(); rsv(9); bus.r1 = 5;
      expect_v("r5_busy", R1B, 32'd1);
      expect_v("cnt1", CNT, 32'd1);
      step(); bus.r1 = 5; bus.r2 = 9;
      expect_v("cnt2", CNT, 32'd2);
      expect_v("r9_busy", R2B, 32'd1);
      step(); wr(5, 32'hAA); bus.r1 = 5;
      expect_v("r5_busy_byp", R1B, 32'd0);
      expect_v("r5_val_byp", R1V, 32'hAA);
      step(); bus.r1 = 5;
      expect_v("cnt_after_w5", CNT, 32'd1);
      expect_v("r5_val", R1V, 32'hAA);
      expect_v("r5_free", R1B, 32'd0);
      step(); rsv(9); wr(9, 32'h1234); bus.r2 = 9;
      expect_v("r9_res_wr_busy", R2B, 32'd1);
      expect_v("r9_byp", R2V, 32'h1234);
      step(); rsv(9); bus.r2 = 9;
      expect_v("cnt_res_wr", CNT, 32'd1);
      expect_v("r9_still_busy", R2B, 32'd1);
      expect_v("r9_val", R2V, 32'h1234);
      step(); rsv(10);
      expect_v("cnt_rereserve", CNT, 32'd1);
      step(); rsv(11);
      step(); bus.r1 = 7; bus.r2 = 10;
      expect_v("cnt3", CNT, 32'd3);
      expect_v("r7_pre_rst", R1V, 32'd88);

      step(); rsv(12); wr(7, 32'd99);
      rst_n = 1'b0;
      expect_v("async_cnt", CNT, 32'd0);
      expect_v("async_r7", R1V, 32'd0);
      expect_v("async_busy", R2B, 32'd0);
      step(); rst_n = 1'b1;
      step(); bus.r1 = 7; bus.r2 = 12;
      expect_v("post_rst_r7", R1V, 32'd0);
      expect_v("post_rst_r12", R2B, 32'd0);
      expect_v("post_rst_cnt", CNT, 32'd0);

      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL queue_drain: got %0d left expected 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the RISC core: two combinational read ports, one general write port, and a dedicated return-address (link) write/read port.
- Adds configurable width and depth, a hardwired zero register, optional write-to-read bypass, and a per-register busy scoreboard.
- The scoreboard lets the issue stage stall on registers whose producers (for example multicycle loads) have not yet written back.
- Sits between decode/issue and writeback.

Parameters:
- DATA_WIDTH, 32, width of each register.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH.
- RA_INDEX, 31, index of the link register written by raWrite.
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes and reserves.
- BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- r1  input  ADDR_WIDTH  read port 1 index.
- r2  input  ADDR_WIDTH  read port 2 index.
- r1_value  output  DATA_WIDTH  read port 1 data.
- r2_value  output  DATA_WIDTH  read port 2 data.
- r3  input  ADDR_WIDTH  write port index.
- r3_value  input  DATA_WIDTH  write port data.
- writeEnable  input  1  commit r3_value to r3 at the next rising edge.
- raWrite  input  1  commit ra_value to RA_INDEX at the next rising edge.
- ra_value  input  DATA_WIDTH  link write data.
- ra_read_value  output  DATA_WIDTH  current link register contents.
- reserveEnable  input  1  mark reserve_reg busy at the next rising edge.
- reserve_reg  input  ADDR_WIDTH  register to reserve.
- r1_busy  output  1  register r1 has an outstanding producer.
- r2_busy  output  1  register r2 has an outstanding producer.
- busyCount  output  ADDR_WIDTH+1  number of busy registers.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all registers and busy bits and zeroes busyCount.
  - Effect is immediate, mid-cycle included; read outputs are 0 while reset is held.
  - Writes and reserves in the cycle reset asserts are discarded.
- Reads:
  - Combinational, zero latency.
  - rX_value = reg[rX], or 0 when ZERO_REG=1 and rX=0.
  - ra_read_value follows the same rules for RA_INDEX.
- Writes:
  - Take effect on the rising edge and are visible the following cycle; latency 1.
  - writeEnable with r3=0 and ZERO_REG=1 is dropped.
- Write collision: writeEnable with r3=RA_INDEX and raWrite in the same cycle → ra_value is stored (link wins).
- Bypass (BYPASS=1): if a write to index rX is pending this cycle, rX_value shows the incoming data combinationally, using the same link-wins priority. This applies to r1, r2 and ra_read_value; index 0 is never bypassed when ZERO_REG=1. With BYPASS=0, the old value is shown until the edge.
- Scoreboard:
  - reserveEnable sets busy[reserve_reg] at the edge; ignored for index 0 when ZERO_REG=1.
  - Any committed write (writeEnable or raWrite) clears busy of the written index.
  - Reserve and write to the same index in one cycle → busy stays set (the new producer wins); the data is still written.
  - Reserving an already-busy register leaves it busy and busyCount unchanged.
- Busy outputs:
  - rX_busy = busy[rX], except with BYPASS=1 it is 0 when a write to rX is pending this cycle and no reserve to rX is pending.
  - r1_busy and r2_busy are always 0 for index 0 when ZERO_REG=1.
- busyCount:
  - Registered population count of the busy bits, updated on the same edge as the busy bits.
  - Range 0..NUM_REGS-1 with ZERO_REG=1, 0..NUM_REGS otherwise.
  - Net change per cycle is in {-2,-1,0,+1}.

Test Plan:
- Reset then read r1=4, r2=2 → r1_value=0, r2_value=0, ra_read_value=0, busyCount=0.
- writeEnable=1, r3=7, r3_value=88 for one cycle, then r1=7 → r1_value=88 next cycle. With BYPASS=1, r1=7 shows 88 during the write cycle; with BYPASS=0 it shows 0 then 88.
- raWrite=1, ra_value=77 together with writeEnable=1, r3=31, r3_value=55 → ra_read_value=77 and r2=31 reads 77; busy[31] is cleared if it was set.
- writeEnable=1, r3=0, r3_value=123 → r1=0 reads 0. Then reserveEnable=1 with reserve_reg=0 → r1=0 gives r1_busy=0 and busyCount stays 0.
- Scoreboard sequence:
  - Reserve 5, then reserve 9 → busyCount=2; r1=5 gives r1_busy=1.
  - Write 5 with value 0xAA → busyCount=1.
  - Reserve 9 and write 9 in the same cycle → busyCount=1, busy[9]=1, reg9=written value.
- Assert rst_n low mid-cycle while busyCount=3 and reg7=88 → busyCount=0 and r1_value=0 for r1=7 immediately, without waiting for a clock edge.
